// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
package pwm_pkg;
  localparam int CNT_W_DEFAULT = 12;
  localparam int MIN_PERIOD    = 2;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } cnt_dir_e;
endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair and the registered compare output.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk_1MHz,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic             apply,
  input  logic [CNT_W-1:0] duty_in,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm_out
);

  logic [CNT_W-1:0] da_r;
  logic [CNT_W-1:0] ds_r;
  logic [CNT_W-1:0] da_eff_s;
  logic             pwm_r;

  // Compare against the duty that governs this cycle, including one being applied now.
  always_comb begin
    da_eff_s = da_r;
    if (apply) begin
      da_eff_s = ds_r;
    end else begin
      da_eff_s = da_r;
    end
  end

  // Duty shadow/active registers and output flop.
  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      da_r  <= {CNT_W{1'b0}};
      ds_r  <= {CNT_W{1'b0}};
      pwm_r <= 1'b0;
    end else begin
      if (apply) begin
        da_r <= ds_r;
      end
      if (load) begin
        ds_r <= duty_in;
      end
      pwm_r <= enable && (cnt < da_eff_s);
    end
  end

  assign pwm_out = pwm_r;

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: shared edge/center-aligned period counter, shadowed
// period/mode/duty applied at period boundaries, and a per-period tick.
module pwm_multichannel
  import pwm_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = CNT_W_DEFAULT,
  parameter int RST_PERIOD = 2000
) (
  input  logic                    clk_1MHz,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [CNT_W-1:0]        period_in,
  input  logic [NUM_CH*CNT_W-1:0] duty_in,
  input  logic                    center_mode,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_tick,
  output logic                    update_pending
);

  localparam logic [CNT_W-1:0] ZERO_C       = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_PERIOD_C = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] RST_PERIOD_C = CNT_W'(RST_PERIOD);

  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  cnt_dir_e         dir_r, dir_nxt_s;
  logic [CNT_W-1:0] pa_r, ps_r;
  pwm_mode_e        ma_r, ms_r;
  logic             pending_r;
  logic             tick_r;
  logic [CNT_W-1:0] pe_s, pe_m1_s;
  logic             boundary_s;
  logic             apply_s;

  // Effective period and the boundary/apply strobes.
  always_comb begin
    pe_s       = (pa_r < MIN_PERIOD_C) ? MIN_PERIOD_C : pa_r;
    pe_m1_s    = pe_s - ONE_C;
    boundary_s = enable && (cnt_r == ZERO_C);
    // While disabled a pending update is applied every cycle.
    apply_s    = pending_r && (boundary_s || !enable);
  end

  // Counter next-state for both alignment modes.
  always_comb begin
    cnt_nxt_s = cnt_r;
    dir_nxt_s = dir_r;
    if (!enable) begin
      cnt_nxt_s = ZERO_C;
      dir_nxt_s = DIR_UP;
    end else begin
      case (ma_r)
        MODE_EDGE: begin
          dir_nxt_s = DIR_UP;
          if (cnt_r >= pe_m1_s) begin
            cnt_nxt_s = ZERO_C;
          end else begin
            cnt_nxt_s = cnt_r + ONE_C;
          end
        end
        MODE_CENTER: begin
          if (dir_r == DIR_UP) begin
            if (cnt_r >= pe_m1_s) begin
              // Minimum period has no down leg: fall straight back to 0.
              cnt_nxt_s = pe_m1_s - ONE_C;
              dir_nxt_s = (pe_m1_s == ONE_C) ? DIR_UP : DIR_DOWN;
            end else begin
              cnt_nxt_s = cnt_r + ONE_C;
              dir_nxt_s = DIR_UP;
            end
          end else begin
            if (cnt_r <= ONE_C) begin
              cnt_nxt_s = ZERO_C;
              dir_nxt_s = DIR_UP;
            end else begin
              cnt_nxt_s = cnt_r - ONE_C;
              dir_nxt_s = DIR_DOWN;
            end
          end
        end
        default: begin
          cnt_nxt_s = ZERO_C;
          dir_nxt_s = DIR_UP;
        end
      endcase
    end
  end

  // Counter, shadow/active period and mode, pending flag and tick.
  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      cnt_r     <= ZERO_C;
      dir_r     <= DIR_UP;
      pa_r      <= RST_PERIOD_C;
      ps_r      <= RST_PERIOD_C;
      ma_r      <= MODE_EDGE;
      ms_r      <= MODE_EDGE;
      pending_r <= 1'b0;
      tick_r    <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      dir_r  <= dir_nxt_s;
      tick_r <= boundary_s;
      if (apply_s) begin
        pa_r <= ps_r;
        ma_r <= ms_r;
      end
      // A load coinciding with apply lands in the shadow and stays pending.
      if (load) begin
        ps_r      <= period_in;
        ms_r      <= pwm_mode_e'(center_mode);
        pending_r <= 1'b1;
      end else if (apply_s) begin
        pending_r <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk_1MHz (clk_1MHz),
      .rst      (rst),
      .enable   (enable),
      .load     (load),
      .apply    (apply_s),
      .duty_in  (duty_in[i*CNT_W +: CNT_W]),
      .cnt      (cnt_r),
      .pwm_out  (pwm_out[i])
    );
  end

  assign period_tick    = tick_r;
  assign update_pending = pending_r;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// period-position reference model.
module tb_pwm_multichannel;
  localparam int NUM_CH     = 4;
  localparam int CNT_W      = 12;
  localparam int RST_PERIOD = 2000;

  logic                    clk_1MHz = 1'b0;
  logic                    rst;
  logic                    enable;
  logic                    load;
  logic [CNT_W-1:0]        period_in;
  logic [NUM_CH*CNT_W-1:0] duty_in;
  logic                    center_mode;
  logic [NUM_CH-1:0]       pwm_out;
  logic                    period_tick;
  logic                    update_pending;

  always #5 clk_1MHz = ~clk_1MHz;

  pwm_multichannel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .RST_PERIOD(RST_PERIOD)) dut (
    .clk_1MHz       (clk_1MHz),
    .rst            (rst),
    .enable         (enable),
    .load           (load),
    .period_in      (period_in),
    .duty_in        (duty_in),
    .center_mode    (center_mode),
    .pwm_out        (pwm_out),
    .period_tick    (period_tick),
    .update_pending (update_pending)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position within the current period, plus register copies.
  int m_pa, m_ps, m_ma, m_ms, m_pend, m_pos;
  int m_da[NUM_CH];
  int m_ds[NUM_CH];
  logic [NUM_CH-1:0] exp_pwm;
  logic              exp_tick;
  logic              exp_pend;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  function automatic int per_len();
    return (m_ma != 0) ? 2 * (eff(m_pa) - 1) : eff(m_pa);
  endfunction

  function automatic int cnt_at(input int pos);
    if (m_ma == 0) return pos;
    return (pos < eff(m_pa)) ? pos : 2 * (eff(m_pa) - 1) - pos;
  endfunction

  task automatic model_step();
    bit bnd, apl;
    int c;
    if (rst) begin
      m_pa = RST_PERIOD; m_ps = RST_PERIOD; m_ma = 0; m_ms = 0; m_pend = 0; m_pos = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_da[i] = 0; m_ds[i] = 0; end
      exp_pwm = '0; exp_tick = 1'b0;
    end else begin
      bnd = enable && (m_pos == 0);
      apl = (m_pend != 0) && (bnd || !enable);
      if (apl) begin
        m_pa = m_ps; m_ma = m_ms;
        for (int i = 0; i < NUM_CH; i++) m_da[i] = m_ds[i];
      end
      c = cnt_at(m_pos);
      for (int i = 0; i < NUM_CH; i++) exp_pwm[i] = enable && (c < m_da[i]);
      exp_tick = bnd;
      if (load) begin
        m_ps = int'(period_in); m_ms = int'(center_mode);
        for (int i = 0; i < NUM_CH; i++) m_ds[i] = int'(duty_in[i*CNT_W +: CNT_W]);
        m_pend = 1;
      end else if (apl) begin
        m_pend = 0;
      end
      m_pos = enable ? (m_pos + 1) % per_len() : 0;
    end
    exp_pend = (m_pend != 0);
  endtask

  // Inputs are set at a negedge; the model steps, then outputs are compared one edge later.
  task automatic cycle();
    model_step();
    @(negedge clk_1MHz);
    check_eq("pwm_out", 32'(pwm_out), 32'(exp_pwm));
    check_eq("period_tick", 32'(period_tick), 32'(exp_tick));
    check_eq("update_pending", 32'(update_pending), 32'(exp_pend));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      if (!load) begin
        period_in   = CNT_W'($urandom);
        duty_in     = {CNT_W'($urandom), CNT_W'($urandom), CNT_W'($urandom), CNT_W'($urandom)};
        center_mode = 1'($urandom);
      end
      cycle();
    end
  endtask

  task automatic do_load(input int p, input int d0, input int d1, input int d2, input int d3, input int m);
    period_in   = CNT_W'(p);
    duty_in     = {CNT_W'(d3), CNT_W'(d2), CNT_W'(d1), CNT_W'(d0)};
    center_mode = (m != 0);
    load        = 1'b1;
    cycle();
    load        = 1'b0;
  endtask

  task automatic measure(input string tag, input int exp_len,
                         input int e0, input int e1, input int e2, input int e3);
    int g, n;
    int hi[NUM_CH];
    int exp_hi[NUM_CH];
    exp_hi = '{e0, e1, e2, e3};
    g = 0;
    while (period_tick !== 1'b1 && g < 5000) begin cycle(); g++; end
    check_eq({tag, "_tick_seen"}, 32'(g < 5000), 32'd1);
    n = 0;
    for (int i = 0; i < NUM_CH; i++) hi[i] = 0;
    do begin
      for (int i = 0; i < NUM_CH; i++) hi[i] += int'(pwm_out[i]);
      n++;
      cycle();
    end while (period_tick !== 1'b1 && n < 5000);
    check_eq({tag, "_len"}, 32'(n), 32'(exp_len));
    for (int i = 0; i < NUM_CH; i++) check_eq({tag, "_high"}, 32'(hi[i]), 32'(exp_hi[i]));
  endtask

  initial begin
    int g, r;
    rst = 1'b1; enable = 1'b0; load = 1'b0;
    period_in = '0; duty_in = '0; center_mode = 1'b0;
    m_pos = 0;
    @(negedge clk_1MHz);
    run(2);
    check_eq("reset_pwm", 32'(pwm_out), 32'd0);
    check_eq("reset_pending", 32'(update_pending), 32'd0);
    rst = 1'b0; enable = 1'b1;

    measure("default", 2000, 0, 0, 0, 0);
    do_load(2000, 1000, 500, 1500, 0, 0);
    measure("edge2000", 2000, 1000, 500, 1500, 0);
    do_load(10, 4, 4, 4, 4, 1);
    measure("center10", 18, 7, 7, 7, 7);

    // Mid-period shadow update, then a load on a boundary cycle.
    run(5);
    do_load(20, 1500, 0, 0, 0, 0);
    check_eq("pending_after_load", 32'(update_pending), 32'd1);
    measure("shadow_mid", 20, 20, 0, 0, 0);
    g = 0;
    while (!(m_pos == 0) && g < 100) begin run(1); g++; end
    do_load(20, 5, 0, 0, 0, 0);
    measure("boundary_old", 20, 20, 0, 0, 0);
    measure("boundary_new", 20, 5, 0, 0, 0);

    // Period and duty limits.
    do_load(0, 1, 1, 0, 2, 0);
    measure("p0", 2, 1, 1, 0, 2);
    do_load(1, 1, 0, 0, 0, 1);
    measure("p1_center", 2, 1, 0, 0, 0);
    do_load(2000, 4095, 0, 4095, 0, 0);
    measure("full_duty", 2000, 2000, 0, 2000, 0);

    // Disable mid-period, load while disabled, re-enable.
    run(7);
    enable = 1'b0;
    cycle();
    check_eq("disabled_pwm", 32'(pwm_out), 32'd0);
    do_load(8, 3, 3, 3, 3, 0);
    run(1);
    check_eq("disabled_apply", 32'(update_pending), 32'd0);
    enable = 1'b1;
    cycle();
    check_eq("reenable_tick", 32'(period_tick), 32'd1);
    measure("after_enable", 8, 3, 3, 3, 3);

    // Reset with an update pending.
    run(3);
    do_load(50, 9, 9, 9, 9, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_eq("rst_pending", 32'(update_pending), 32'd0);
    measure("after_rst", 2000, 0, 0, 0, 0);

    // Random mix of loads, enable toggles and resets.
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        do_load($urandom_range(0, 20), $urandom_range(0, 24), $urandom_range(0, 24),
                $urandom_range(0, 24), $urandom_range(0, 24), $urandom_range(0, 1));
      end else if (r < 8) begin
        enable = ($urandom_range(0, 3) != 0);
      end else if (r == 8) begin
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end else begin
        enable = 1'b1;
      end
      run($urandom_range(1, 50));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multichannel.md
# pwm_multichannel

Parametrised multi-channel PWM generator, the next generation of the single-channel 500 Hz PWM block. It provides a shared programmable period counter, NUM_CH independent duty comparators, edge-aligned or center-aligned mode, and double-buffered (shadowed) configuration that only changes at period boundaries. It sits on the clk_1MHz domain and drives motor/LED outputs. A per-period tick replaces the old divided-clock output.

## Interface
- NUM_CH, 4: number of PWM channels
- CNT_W, 12: counter, period and duty width in bits
- RST_PERIOD, 2000: active period after reset (500 Hz at 1 MHz, edge mode)
- clk_1MHz  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  1 = run; 0 = counter held at 0, outputs low
- load  in  1  single-cycle strobe; captures period_in, duty_in and center_mode into the shadow registers
- period_in  in  CNT_W  requested period P, in counter steps
- duty_in  in  NUM_CH*CNT_W  requested duty per channel; channel i at bits [i*CNT_W +: CNT_W]
- center_mode  in  1  0 = edge-aligned, 1 = center-aligned
- pwm_out  out  NUM_CH  registered PWM outputs
- period_tick  out  1  one-cycle pulse at the start of each period
- update_pending  out  1  shadow holds values not yet applied

## Operation
- Registers per block:
  - active period Pa, mode Ma, counter cnt, direction dir
  - shadow period Ps, mode Ms, pending flag
  - per channel: active duty Da[i], shadow duty Ds[i]
- Effective period: Pe = max(Pa, 2). Values 0 and 1 are treated as 2.
- Edge mode:
  - cnt counts 0, 1, ..., Pe-1, then wraps to 0.
  - Period length is Pe cycles.
- Center mode:
  - cnt counts up 0..Pe-1, then down Pe-2..1, then returns to 0.
  - Period length is 2*(Pe-1) cycles.
  - dir flips at Pe-1 and at 1.
- Compare: the channel-i raw output is (cnt < Da[i]).
  - Da[i] = 0 gives constant low.
  - Da[i] ≥ Pe gives constant high.
  - No glitch at the boundary.
- Boundary: any cycle in which cnt = 0 and enable = 1.
- load:
  - Ps, Ms, Ds[*] ← inputs; pending ← 1.
  - A later load before apply overwrites the shadow (last write wins).
- Apply: at a boundary with pending = 1:
  - Pa ← Ps, Ma ← Ms, Da[*] ← Ds[*], pending ← 0.
  - The new values govern the period beginning at that boundary.
- load in the same cycle as a boundary:
  - The boundary applies the old shadow contents.
  - The new load is written into the shadow and pending stays 1.
  - The new values take effect at the next boundary.
- enable = 0:
  - cnt ← 0 and dir ← up.
  - pwm_out and period_tick are 0.
  - If pending = 1, apply happens every cycle, so configuration is immediate while disabled.
- Mode change takes effect only at apply. The counter always restarts from 0 going up.
- update_pending = pending.

## Timing
- Reset values:
  - cnt = 0, dir = up, Pa = Ps = RST_PERIOD, Ma = Ms = 0, Da = Ds = 0, pending = 0
  - pwm_out = 0, period_tick = 0, update_pending = 0
- Reset mid-period discards the shadow and any pending update.
- Output latency is 1 cycle: pwm_out[i] in cycle t+1 equals (cnt(t) < Da[i]).
- period_tick in cycle t+1 is 1 iff cycle t was a boundary. It is aligned with the first pwm_out sample of the period.
- First enabled cycle after enable rises is a boundary. The tick appears in the cycle after that.
- load is honoured when enable = 0.
- rst has priority over load and enable.

## Structure
- Package pwm_pkg contains:
  - MODE_EDGE = 1'b0 and MODE_CENTER = 1'b1
  - MIN_PERIOD = 2
  - default CNT_W
- Sub-module pwm_channel, instantiated NUM_CH times via generate. It holds Ds/Da for one channel, takes apply and load strobes from the top, and contains the output compare flop.
- The top module holds the counter, direction, shadow period/mode, pending flag and tick logic.

## Test plan
- Reset then enable, NUM_CH=4, CNT_W=12:
  - No load: period_tick every 2000 cycles; all pwm_out low.
- load P=2000, duties {1000,500,1500,0}, edge mode:
  - Per period, high counts are 1000/500/1500/0.
  - Tick spacing is 2000.
- Center mode, P=10, duty 4:
  - Period is 18 cycles; high 7 cycles per period (cnt 0-3 up, 3-1 down).
  - Output is symmetric about cnt = 9.
- Shadowing:
  - load duty 1500 mid-period: update_pending = 1; old duty holds until the next tick; new duty applies from that tick and pending clears.
  - load on a boundary cycle: new duty is deferred one full period.
- Limits:
  - P=0 or P=1 gives period 2.
  - Duty 4095 with P=2000 gives constant high.
  - Duty 0 gives constant low.
- Disable and reset:
  - enable=0 mid-period: outputs low next cycle.
  - load while disabled takes effect immediately; re-enable gives a tick one cycle after the first enabled cycle.
  - rst during a pending update restores the reset values.
